// File: rtl/fb_pkg.sv
// fb_pkg: frame buffer geometry, pixel layout and writer state encoding shared with the display reader.
package fb_pkg;
    localparam int FB_W      = 400;
    localparam int FB_H      = 300;
    localparam int PIX_W     = 6;
    localparam int ADDR_W    = 17;
    localparam int FB_PIXELS = FB_W * FB_H;
    localparam int CH_W      = 2;
    localparam int R_LSB     = 4;
    localparam int G_LSB     = 2;
    localparam int B_LSB     = 0;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_SWAP
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;
endpackage

// File: rtl/fb_addr_counter.sv
// fb_addr_counter: x/y raster position with a running linear address, so no y*FB_W multiply is needed.
module fb_addr_counter #(
    parameter int W  = fb_pkg::FB_W,
    parameter int H  = fb_pkg::FB_H,
    parameter int AW = fb_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_restart,
    input  logic          i_advance,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic          w_x_end;

    assign w_x_end = r_x == XW'(W - 1);
    assign o_last  = w_x_end && r_y == YW'(H - 1);
    assign o_addr  = r_addr;

    // restart means pixel 0 is being written right now, so the next pixel is at x=1
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_restart) begin
            r_x    <= XW'(1);
            r_y    <= '0;
            r_addr <= AW'(1);
        end else if (i_advance) begin
            r_x    <= w_x_end ? '0 : r_x + 1'b1;
            r_y    <= w_x_end ? r_y + 1'b1 : r_y;
            r_addr <= r_addr + 1'b1;
        end
    end
endmodule

// File: rtl/fb_stream_writer.sv
// fb_stream_writer: writes a valid/ready pixel stream into a double-buffered frame buffer, swapping banks in vblank.
module fb_stream_writer #(
    parameter int FB_W   = fb_pkg::FB_W,
    parameter int FB_H   = fb_pkg::FB_H,
    parameter int PIX_W  = fb_pkg::PIX_W,
    parameter int ADDR_W = fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_sof,
    input  logic              vblank,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              sof_err,
    output logic              drop
);
    import fb_pkg::*;

    state_t              r_state;
    state_t              w_next;
    logic                w_xfer;
    logic                w_write;
    logic                w_restart;
    logic                w_advance;
    logic                w_swap;
    logic                w_done;
    logic                w_sof_err;
    logic                w_drop;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [PIX_W-1:0]    r_wr_data;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                r_frame_done;
    logic                r_sof_err;
    logic                r_drop;

    assign w_xfer = s_valid && s_ready;

    fb_addr_counter #(
        .W  (FB_W),
        .H  (FB_H),
        .AW (ADDR_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_swap),
        .i_restart (w_restart),
        .i_advance (w_advance),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // s_sof on the final pixel is a resync, so completion requires !s_sof
    always_comb begin
        w_next = r_state == IDLE  ? ((w_xfer && s_sof) ? WRITE : IDLE)
               : r_state == WRITE ? ((w_xfer && !s_sof && w_last) ? WAIT_SWAP : WRITE)
               : (vblank ? IDLE : WAIT_SWAP);
    end

    always_comb begin
        s_ready   = r_state != WAIT_SWAP;
        w_write   = w_xfer && (r_state == WRITE || s_sof);
        w_restart = w_xfer && s_sof;
        w_sof_err = w_xfer && s_sof && r_state == WRITE;
        w_drop    = w_xfer && !s_sof && r_state == IDLE;
        w_done    = w_xfer && !s_sof && r_state == WRITE && w_last;
        w_advance = w_xfer && !s_sof && r_state == WRITE && !w_last;
        w_swap    = r_state == WAIT_SWAP && vblank;
    end

    // the swap is always at least one cycle after the final write, so that write keeps the old bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_bank    <= 1'b1;
            r_rd_bank    <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_wr_en      <= w_write;
            r_frame_done <= w_done;
            r_sof_err    <= w_sof_err;
            r_drop       <= w_drop;
            r_rd_bank    <= r_rd_bank ^ w_swap;
            r_wr_bank    <= ~(r_rd_bank ^ w_swap);
            if (w_write) begin
                r_wr_addr <= s_sof ? '0 : w_addr;
                r_wr_data <= s_data;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_bank    = r_wr_bank;
    assign rd_bank    = r_rd_bank;
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;
    assign drop       = r_drop;
endmodule

// File: tb/tb_fb_stream_writer.sv
// tb_fb_stream_writer: directed checks of the stream writer on a 400x3 frame (row wrap at 399/400, last address 1199).
module tb_fb_stream_writer;
    localparam int W  = 400;
    localparam int H  = 3;
    localparam int AW = 11;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          vblank = 1'b0;
    logic [5:0]    s_data = '0;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_data;
    logic          wr_bank;
    logic          rd_bank;
    logic          frame_done;
    logic          sof_err;
    logic          drop;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    fb_stream_writer #(
        .FB_W   (W),
        .FB_H   (H),
        .PIX_W  (6),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .vblank     (vblank),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_bank    (wr_bank),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .drop       (drop)
    );

    // {wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_done, sof_err, drop, s_ready}
    function automatic logic [23:0] obs();
        return {wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_done, sof_err, drop, s_ready};
    endfunction

    // drive at negedge; after return, registered outputs reflect this cycle's transfer
    task automatic step(input logic v, input logic sof, input logic [5:0] d);
        s_valid = v;
        s_sof   = sof;
        s_data  = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [23:0] e;
        rst_n = 1'b0;
        step(1'b1, 1'b0, 6'h3F);
        e = {1'b0, 11'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset: got %h want %h", obs(), e);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        logic [23:0] e;
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, 6'(i % 64));
            e = {1'b1, 11'(i), 6'(i % 64), 1'b1, 1'b0, i == N - 1, 1'b0, 1'b0, i != N - 1};
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL full_frame px %0d: got %h want %h", i, obs(), e);
            end
        end
        step(1'b0, 1'b0, 6'd0);
        e = {1'b0, 11'd1199, 6'd47, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL full_frame idle: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_swap();
        logic [23:0] e;
        vblank = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 6'd5);
            e = {1'b0, 11'd1199, 6'd47, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL swap_wait cyc %0d: got %h want %h", i, obs(), e);
            end
        end
        vblank = 1'b1;
        step(1'b0, 1'b0, 6'd0);
        e = {1'b0, 11'd1199, 6'd47, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL swap_vblank: got %h want %h", obs(), e);
        end
        vblank = 1'b0;
    endtask

    task automatic test_drop();
        logic [23:0] e;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 6'(k + 1));
            e = {1'b0, 11'd1199, 6'd47, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL drop %0d: got %h want %h", k, obs(), e);
            end
        end
        step(1'b1, 1'b1, 6'h2A);
        e = {1'b1, 11'd0, 6'h2A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL drop_then_sof: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_stall_wrap();
        logic [23:0] e;
        for (int p = 1; p <= 410; p++) begin
            if (p >= 396 && p <= 404) begin
                for (int g = 0; g < p % 3; g++) begin
                    step(1'b0, 1'b0, 6'h11);
                    e = {1'b0, 11'(p - 1), (p == 1) ? 6'h2A : 6'((p - 1) % 64), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
                    n_cmp++;
                    if (obs() !== e) begin
                        n_err++;
                        $display("FAIL stall before px %0d: got %h want %h", p, obs(), e);
                    end
                end
            end
            step(1'b1, 1'b0, 6'(p % 64));
            e = {1'b1, 11'(p), 6'(p % 64), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL wrap px %0d: got %h want %h", p, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] e;
        for (int p = 411; p < 500; p++) begin
            step(1'b1, 1'b0, 6'(p % 64));
            e = {1'b1, 11'(p), 6'(p % 64), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL pre_reset px %0d: got %h want %h", p, obs(), e);
            end
        end
        rst_n = 1'b0;
        step(1'b1, 1'b0, 6'(500 % 64));
        e = {1'b0, 11'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid: got %h want %h", obs(), e);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b1, 6'h15);
        e = {1'b1, 11'd0, 6'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid_sof: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_resync();
        logic [23:0] e;
        for (int p = 1; p < 1000; p++) begin
            step(1'b1, 1'b0, 6'(p % 64));
            e = {1'b1, 11'(p), 6'(p % 64), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL pre_resync px %0d: got %h want %h", p, obs(), e);
            end
        end
        step(1'b1, 1'b1, 6'h3C);
        e = {1'b1, 11'd0, 6'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL resync: got %h want %h", obs(), e);
        end
        for (int j = 1; j < N; j++) begin
            if (j == N - 1)
                vblank = 1'b1;
            step(1'b1, 1'b0, 6'(j % 64));
            e = {1'b1, 11'(j), 6'(j % 64), 1'b1, 1'b0, j == N - 1, 1'b0, 1'b0, j != N - 1};
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL post_resync px %0d: got %h want %h", j, obs(), e);
            end
        end
        step(1'b0, 1'b0, 6'd0);
        e = {1'b0, 11'd1199, 6'd47, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL early_vblank_swap: got %h want %h", obs(), e);
        end
        vblank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_swap();
        test_drop();
        test_stall_wrap();
        test_reset_mid();
        test_resync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
